// File: rtl/mem_wb_pipe_pkg.sv
// rtl/mem_wb_pipe_pkg.sv - shared defines and payload packing layout for the MEM/WB pipe
package mem_wb_pipe_pkg;

    localparam logic        RstEnable    = 1'b1;
    localparam logic        WriteDisable = 1'b0;
    localparam logic [31:0] ZeroWord     = 32'h0000_0000;
    localparam logic [4:0]  NOPRegAddr   = 5'b00000;

    // Packed payload layout, MSB to LSB: {wd, wreg, wdata, hi, lo, whilo}
    function automatic int payload_w(input int addr_w, input int data_w);
        return addr_w + 3 * data_w + 2;
    endfunction

    function automatic int off_whilo();
        return 0;
    endfunction

    function automatic int off_lo();
        return 1;
    endfunction

    function automatic int off_hi(input int data_w);
        return 1 + data_w;
    endfunction

    function automatic int off_wdata(input int data_w);
        return 1 + 2 * data_w;
    endfunction

    function automatic int off_wreg(input int data_w);
        return 1 + 3 * data_w;
    endfunction

    function automatic int off_wd(input int data_w);
        return 2 + 3 * data_w;
    endfunction

endpackage

// File: rtl/mem_wb_pipe_skid_buf.sv
// rtl/mem_wb_pipe_skid_buf.sv - generic two-entry (main + skid) pipeline buffer
module pipe_skid_buf
    import mem_wb_pipe_pkg::*;
#(
    parameter int             W         = 8,
    parameter logic [W-1:0]   RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         main_valid;
    logic         skid_valid;
    logic [W-1:0] main_data;
    logic [W-1:0] skid_data;
    logic         in_hs;
    logic         out_hs;

    // Acceptance depends only on the skid slot, so in_ready never combinationally sees out_ready
    assign in_ready  = ~skid_valid;
    assign out_valid = main_valid;
    assign out_data  = main_data;
    assign in_hs     = in_valid & in_ready;
    assign out_hs    = main_valid & out_ready;

    // Entry movement: flush wins; skid drains into main before any new payload lands
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_data  <= RESET_VAL;
            skid_data  <= RESET_VAL;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (out_hs && skid_valid) begin
            main_data  <= skid_data;
            skid_valid <= 1'b0;
        end else if (in_hs && (!main_valid || out_ready)) begin
            main_data  <= in_data;
            main_valid <= 1'b1;
        end else if (in_hs) begin
            skid_data  <= in_data;
            skid_valid <= 1'b1;
        end else if (out_hs) begin
            main_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_wb_pipe.sv
// rtl/mem_wb_pipe.sv - MEM/WB pipeline register with skid buffering and retire counter
module mem_wb_pipe
    import mem_wb_pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] mem_wd,
    input  logic              mem_wreg,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_hi,
    input  logic [DATA_W-1:0] mem_lo,
    input  logic              mem_whilo,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [ADDR_W-1:0] wb_wd,
    output logic              wb_wreg,
    output logic [DATA_W-1:0] wb_wdata,
    output logic [DATA_W-1:0] wb_hi,
    output logic [DATA_W-1:0] wb_lo,
    output logic              wb_whilo,
    output logic [CNT_W-1:0]  retire_cnt
);

    localparam int PW       = payload_w(ADDR_W, DATA_W);
    localparam int O_WHILO  = off_whilo();
    localparam int O_LO     = off_lo();
    localparam int O_HI     = off_hi(DATA_W);
    localparam int O_WDATA  = off_wdata(DATA_W);
    localparam int O_WREG   = off_wreg(DATA_W);
    localparam int O_WD     = off_wd(DATA_W);

    localparam logic [ADDR_W-1:0] NOP_ADDR  = ADDR_W'(NOPRegAddr);
    localparam logic [DATA_W-1:0] ZERO_DATA = DATA_W'(ZeroWord);
    localparam logic [PW-1:0]     PL_RESET  = {NOP_ADDR, {(PW - ADDR_W){1'b0}}};

    logic [PW-1:0] in_pl;
    logic [PW-1:0] head_pl;
    logic          head_valid;

    // Pack the MEM payload in the shared field order
    always_comb begin
        in_pl                       = '0;
        in_pl[O_WD +: ADDR_W]       = mem_wd;
        in_pl[O_WREG]               = mem_wreg;
        in_pl[O_WDATA +: DATA_W]    = mem_wdata;
        in_pl[O_HI +: DATA_W]       = mem_hi;
        in_pl[O_LO +: DATA_W]       = mem_lo;
        in_pl[O_WHILO]              = mem_whilo;
    end

    pipe_skid_buf #(
        .W         (PW),
        .RESET_VAL (PL_RESET)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_pl),
        .out_valid (head_valid),
        .out_ready (out_ready),
        .out_data  (head_pl)
    );

    assign out_valid = head_valid;

    // Present a harmless no-op writeback whenever the head slot is empty
    always_comb begin
        wb_wd    = NOP_ADDR;
        wb_wreg  = WriteDisable;
        wb_wdata = ZERO_DATA;
        wb_hi    = ZERO_DATA;
        wb_lo    = ZERO_DATA;
        wb_whilo = WriteDisable;
        if (head_valid) begin
            wb_wd    = head_pl[O_WD +: ADDR_W];
            wb_wreg  = head_pl[O_WREG];
            wb_wdata = head_pl[O_WDATA +: DATA_W];
            wb_hi    = head_pl[O_HI +: DATA_W];
            wb_lo    = head_pl[O_LO +: DATA_W];
            wb_whilo = head_pl[O_WHILO];
        end
    end

    // Count every completed output handshake, including those in a flush cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            retire_cnt <= '0;
        end else if (head_valid && out_ready) begin
            retire_cnt <= retire_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_mem_wb_pipe.sv
// tb/tb_mem_wb_pipe.sv - self-checking bench for mem_wb_pipe
module tb_mem_wb_pipe;

    typedef struct packed {
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        whilo;
    } pl_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic [31:0] mem_hi;
    logic [31:0] mem_lo;
    logic        mem_whilo;
    logic        out_ready;
    logic        out_valid;
    logic [4:0]  wb_wd;
    logic        wb_wreg;
    logic [31:0] wb_wdata;
    logic [31:0] wb_hi;
    logic [31:0] wb_lo;
    logic        wb_whilo;
    logic [3:0]  retire_cnt;

    int total = 0;
    int bad   = 0;

    pl_t        mq[$];
    logic [3:0] m_cnt;

    mem_wb_pipe #(.DATA_W(32), .ADDR_W(5), .CNT_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .mem_wd     (mem_wd),
        .mem_wreg   (mem_wreg),
        .mem_wdata  (mem_wdata),
        .mem_hi     (mem_hi),
        .mem_lo     (mem_lo),
        .mem_whilo  (mem_whilo),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .wb_wd      (wb_wd),
        .wb_wreg    (wb_wreg),
        .wb_wdata   (wb_wdata),
        .wb_hi      (wb_hi),
        .wb_lo      (wb_lo),
        .wb_whilo   (wb_whilo),
        .retire_cnt (retire_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected outputs follow from a depth-2 FIFO view of the block
    task automatic check_all(input string tag);
        pl_t h;
        logic v;
        v = (mq.size() > 0);
        h = v ? mq[0] : '0;
        check({tag, ".out_valid"}, 64'(out_valid), 64'(v));
        check({tag, ".in_ready"},  64'(in_ready),  64'(mq.size() < 2));
        check({tag, ".wb_wd"},     64'(wb_wd),     64'(h.wd));
        check({tag, ".wb_wreg"},   64'(wb_wreg),   64'(h.wreg));
        check({tag, ".wb_wdata"},  64'(wb_wdata),  64'(h.wdata));
        check({tag, ".wb_hi"},     64'(wb_hi),     64'(h.hi));
        check({tag, ".wb_lo"},     64'(wb_lo),     64'(h.lo));
        check({tag, ".wb_whilo"},  64'(wb_whilo),  64'(h.whilo));
        check({tag, ".retire"},    64'(retire_cnt), 64'(m_cnt));
    endtask

    function automatic pl_t rand_pl();
        pl_t p;
        p.wd    = 5'($urandom);
        p.wreg  = 1'($urandom);
        p.wdata = $urandom;
        p.hi    = $urandom;
        p.lo    = $urandom;
        p.whilo = 1'($urandom);
        return p;
    endfunction

    // One clock: drive at the falling edge, update the model at the rising edge, check at the next falling edge
    task automatic cycle(input string tag, input logic iv, input logic ordy, input logic fl, input pl_t p);
        logic ihs;
        logic ohs;
        in_valid  = iv;
        out_ready = ordy;
        flush     = fl;
        mem_wd    = p.wd;
        mem_wreg  = p.wreg;
        mem_wdata = p.wdata;
        mem_hi    = p.hi;
        mem_lo    = p.lo;
        mem_whilo = p.whilo;
        ihs = iv && (mq.size() < 2);
        ohs = ordy && (mq.size() > 0);
        @(posedge clk);
        if (ohs) begin
            void'(mq.pop_front());
            m_cnt = m_cnt + 4'd1;
        end
        if (fl) mq.delete();
        else if (ihs) mq.push_back(p);
        @(negedge clk);
        check_all(tag);
    endtask

    // Reset asserted between edges; outputs must clear before any clock edge
    task automatic pulse_reset(input string tag);
        #2;
        rst = 1'b1;
        mq.delete();
        m_cnt = 4'd0;
        #1;
        check_all({tag, ".async"});
        @(negedge clk);
        check_all({tag, ".held"});
        rst = 1'b0;
    endtask

    initial begin
        pl_t pa, pb, pc;
        rst = 1'b1;
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        mem_wd = '0; mem_wreg = 1'b0; mem_wdata = '0;
        mem_hi = '0; mem_lo = '0; mem_whilo = 1'b0;
        m_cnt = 4'd0;

        #2;
        check_all("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_all("post_reset");

        // Single payload through an empty block
        pa = '0; pa.wd = 5'd3; pa.wdata = 32'h1234_5678; pa.wreg = 1'b1;
        cycle("first", 1'b1, 1'b1, 1'b0, pa);
        check("first.wb_wd_const", 64'(wb_wd), 64'd3);
        check("first.wb_wdata_const", 64'(wb_wdata), 64'h1234_5678);
        cycle("first_drain", 1'b0, 1'b1, 1'b0, '0);
        check("first.retire_const", 64'(retire_cnt), 64'd1);

        // Push A then B while stalled; both drain in order
        pa = rand_pl();
        pb = rand_pl();
        cycle("stall_a", 1'b1, 1'b0, 1'b0, pa);
        cycle("stall_b", 1'b1, 1'b0, 1'b0, pb);
        check("stall_b.in_ready_low", 64'(in_ready), 64'd0);
        pc = rand_pl();
        cycle("stall_hold1", 1'b1, 1'b0, 1'b0, pc);
        cycle("stall_hold2", 1'b0, 1'b0, 1'b0, pc);
        cycle("drain_a", 1'b0, 1'b1, 1'b0, '0);
        check("drain_a.head_b", 64'(wb_wdata), 64'(pb.wdata));
        cycle("drain_b", 1'b0, 1'b1, 1'b0, '0);
        check("drain_b.in_ready_high", 64'(in_ready), 64'd1);

        // Flush with both entries full and a payload offered
        cycle("fill1", 1'b1, 1'b0, 1'b0, rand_pl());
        cycle("fill2", 1'b1, 1'b0, 1'b0, rand_pl());
        cycle("flush_full", 1'b1, 1'b0, 1'b1, rand_pl());
        check("flush_full.out_valid_low", 64'(out_valid), 64'd0);

        // HI/LO-only payload
        pa = '0; pa.hi = 32'hA; pa.lo = 32'hB; pa.whilo = 1'b1; pa.wreg = 1'b0;
        cycle("whilo", 1'b1, 1'b0, 1'b0, pa);
        check("whilo.hi_const", 64'(wb_hi), 64'hA);

        // Output handshake during a flush still retires
        cycle("flush_retire", 1'b0, 1'b1, 1'b1, '0);

        // Counter wrap: 17 retirements from reset on a 4-bit counter
        pulse_reset("rst_wrap");
        for (int i = 0; i < 17; i++) cycle("stream", 1'b1, 1'b1, 1'b0, rand_pl());
        cycle("stream_end", 1'b0, 1'b1, 1'b0, '0);
        check("wrap.retire_const", 64'(retire_cnt), 64'd1);

        // Asynchronous reset while both entries are full, then normal restart
        cycle("full1", 1'b1, 1'b0, 1'b0, rand_pl());
        cycle("full2", 1'b1, 1'b0, 1'b0, rand_pl());
        pulse_reset("rst_full");
        cycle("restart", 1'b1, 1'b0, 1'b0, rand_pl());

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cycle("rand", 1'($urandom), 1'($urandom), ($urandom_range(0, 19) == 0), rand_pl());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_wb_pipe.md
MEM_WB_PIPE -- requirements
Module: mem_wb_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of the GPR, HI and LO data buses.
REQ-002 SHALL have parameter ADDR_W, default 5, width of the register address.
REQ-003 SHALL have parameter CNT_W, default 32, width of the retire counter.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset, asynchronous and active-high.
REQ-006 flush  in  1  discard all held and incoming entries this cycle.
REQ-007 in_valid  in  1  MEM stage presents a payload.
REQ-008 in_ready  out  1  block can accept a payload.
REQ-009 mem_wd, mem_wreg, mem_wdata  in  ADDR_W/1/DATA_W  GPR write payload.
REQ-010 mem_hi, mem_lo, mem_whilo  in  DATA_W/DATA_W/1  HI/LO write payload.
REQ-011 out_ready  in  1  writeback side consumes the head entry.
REQ-012 out_valid  out  1  head entry is valid.
REQ-013 wb_wd, wb_wreg, wb_wdata, wb_hi, wb_lo, wb_whilo  out  as inputs  head payload.
REQ-014 retire_cnt  out  CNT_W  count of completed output handshakes.

Function
REQ-015 SHALL hold up to two payloads: a main entry (head) and a skid entry, each with its own valid bit.
REQ-016 in_ready SHALL equal NOT skid_valid, combinationally from state only, with no path from out_ready.
REQ-017 An input handshake (in_valid AND in_ready) SHALL load the main entry if main is empty, or if main is full and out_ready is high.
REQ-018 Otherwise, an input handshake SHALL load the skid entry.
REQ-019 An output handshake (out_valid AND out_ready) with skid valid SHALL move skid to main and clear skid_valid in the same edge.
REQ-020 Latency SHALL be 1 cycle from input handshake to out_valid when the block is empty.
REQ-021 Throughput SHALL be 1 payload per cycle while out_ready stays high.
REQ-022 Payload order SHALL be preserved; no payload is dropped or duplicated except by flush.
REQ-023 out_valid SHALL equal main_valid.
REQ-024 wb_wreg SHALL equal main_valid AND the stored wreg.
REQ-025 wb_whilo SHALL equal main_valid AND the stored whilo.
REQ-026 When main is invalid, wb_wd SHALL be NOPRegAddr and wb_wdata, wb_hi and wb_lo SHALL be ZeroWord.
REQ-027 flush SHALL clear both valid bits at the next edge and discard any input presented that cycle.
REQ-028 An output handshake in a flush cycle SHALL still count.
REQ-029 flush SHALL take priority over all load and move actions.
REQ-030 retire_cnt SHALL increment by 1 on each output handshake and wrap from 2^CNT_W-1 to 0.
REQ-031 On simultaneous output handshake and input handshake with the skid empty, the new payload SHALL load main directly.
REQ-032 Stall (out_ready low) with both entries full SHALL hold all outputs stable and keep in_ready low.

Reset
REQ-033 While rst is high, both valid bits SHALL be 0 and stored payloads SHALL be zero, with stored wd equal to NOPRegAddr.
REQ-034 While rst is high, retire_cnt SHALL be 0 and in_ready SHALL be 1.
REQ-035 Reset asserted mid-operation SHALL discard held entries immediately, without waiting for a clock edge.
REQ-036 The first input handshake after reset release SHALL be accepted normally.

Structure
REQ-037 RstEnable, WriteDisable, ZeroWord and NOPRegAddr SHALL come from the shared defines file.
REQ-038 Payload field widths and their packing order SHALL be defined once in that shared file.
REQ-039 The two-entry storage SHALL be a generic sub-module pipe_skid_buf, parametrised by payload width.
REQ-040 mem_wb_pipe SHALL instantiate pipe_skid_buf and add payload packing, write-enable gating and the counter.

Verification
REQ-041 Test: after reset, in_valid=1, out_ready=1, mem_wd=3, mem_wdata=0x12345678, mem_wreg=1 for one cycle -> next cycle out_valid=1, wb_wd=3, wb_wdata=0x12345678, wb_wreg=1; retire_cnt=1 after the following edge.
REQ-042 Test: out_ready=0, push A then B -> in_ready=0 after B; head=A; raise out_ready -> A then B on consecutive cycles; in_ready returns to 1.
REQ-043 Test: both entries full, flush=1 with in_valid=1 -> next cycle out_valid=0, wb_wreg=0, wb_whilo=0, wb_wd=0, in_ready=1.
REQ-044 Test: whilo payload hi=0xA, lo=0xB, mem_whilo=1, mem_wreg=0 -> wb_hi=0xA, wb_lo=0xB, wb_whilo=1, wb_wreg=0.
REQ-045 Test: CNT_W=4, 17 handshakes -> retire_cnt=1.
REQ-046 Test: rst pulsed between clock edges while both entries are full -> outputs zero immediately, before the next edge.
